// File: rtl/program_counter.sv
// Program counter with a four-state control FSM (IDLE, RUN, STALL, HALT).
// PC_out is registered. PC_next_seq is the combinational PC_out+STEP that
// feeds the ALU operand mux. Retired counts PC writes and saturates at 255.
//
// Handshake: the block presents an address on PC_out; Valid=1 marks a
// fetchable address (RUN or STALL). There is no back-pressure input. Enable
// grants advancement and Stall/Halt request holds, all sampled on the rising edge.
module program_counter #(
    parameter int WIDTH = 6,
    parameter int STEP  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Enable,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             Jump,
    input  logic [WIDTH-1:0] Jump_addr,
    input  logic             Branch,
    input  logic [WIDTH-1:0] Branch_off,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_next_seq,
    output logic             Valid,
    output logic             Halted,
    output logic [7:0]       Retired,
    output logic [1:0]       Dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Redirect targets are word aligned: the two low bits are cleared.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [7:0]       RET_MAX    = 8'hFF;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [7:0]       ret_q, ret_d;

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] branch_tgt;
    logic             advance;

    // Candidate next addresses; the adders wrap modulo 2^WIDTH, which also
    // gives the correct two's-complement result for a negative Branch_off.
    always_comb begin
        pc_seq     = pc_q + WIDTH'(STEP);
        jump_tgt   = Jump_addr & ALIGN_MASK;
        branch_tgt = (pc_q + Branch_off) & ALIGN_MASK;
    end

    // Next-state logic: priority Halt > Stall > Jump > Branch > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN, STALL: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (Stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    if (Enable) begin
                        advance = 1'b1;
                        if (Jump) begin
                            pc_d = jump_tgt;
                        end else if (Branch) begin
                            pc_d = branch_tgt;
                        end else begin
                            pc_d = pc_seq;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (advance && (ret_q != RET_MAX)) begin
            ret_d = ret_q + 8'd1;
        end
    end

    // State, PC and retire counter registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    // Registered outputs and status decoded from the current state.
    always_comb begin
        PC_out      = pc_q;
        PC_next_seq = pc_seq;
        Valid       = (state_q == RUN) || (state_q == STALL);
        Halted      = (state_q == HALT);
        Retired     = ret_q;
        Dbg_state   = state_q;
    end

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vectors with hand-computed expectations
// pushed into a queue by the driver and popped by an independent monitor.
module tb_program_counter;

  localparam int W = 6;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         Enable;
  logic         Stall;
  logic         Halt;
  logic         Jump;
  logic [W-1:0] Jump_addr;
  logic         Branch;
  logic [W-1:0] Branch_off;
  logic [W-1:0] PC_out;
  logic [W-1:0] PC_next_seq;
  logic         Valid;
  logic         Halted;
  logic [7:0]   Retired;
  logic [1:0]   Dbg_state;

  // expected record: {pc[5:0], valid, halted, retired[7:0]}
  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  program_counter #(.WIDTH(W), .STEP(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Enable      (Enable),
    .Stall       (Stall),
    .Halt        (Halt),
    .Jump        (Jump),
    .Jump_addr   (Jump_addr),
    .Branch      (Branch),
    .Branch_off  (Branch_off),
    .PC_out      (PC_out),
    .PC_next_seq (PC_next_seq),
    .Valid       (Valid),
    .Halted      (Halted),
    .Retired     (Retired),
    .Dbg_state   (Dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  task automatic quiet();
    Stall      = 1'b0;
    Halt       = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    Jump_addr  = '0;
    Branch_off = '0;
  endtask

  // Push the state expected after the coming rising edge, then advance.
  task automatic tick(input logic [W-1:0] pc, input logic v, input logic h,
                      input logic [7:0] r);
    exp_q.push_back({pc, v, h, r});
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [15:0]  e;
    logic [W-1:0] e_pc;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        e_pc = e[15:10];
        check("pc_out",      16'(PC_out),      16'(e_pc));
        check("pc_next_seq", 16'(PC_next_seq), 16'(W'(e_pc + W'(4))));
        check("valid",       16'(Valid),       16'(e[9]));
        check("halted",      16'(Halted),      16'(e[8]));
        check("retired",     16'(Retired),     16'(e[7:0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    if (!done) begin
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    RST_N  = 1'b0;
    Enable = 1'b1;
    quiet();

    // reset, with requests pending that must be ignored
    Jump = 1'b1; Jump_addr = 6'd20; Halt = 1'b1;
    tick(6'd0, 1'b0, 1'b0, 8'd0);
    quiet();
    tick(6'd0, 1'b0, 1'b0, 8'd0);

    // release: IDLE -> RUN with PC 0, then 16 sequential advances with wrap
    RST_N = 1'b1;
    tick(6'd0, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 16; i++) tick(W'(4 * i), 1'b1, 1'b0, 8'(i));

    // Enable=0 holds PC and Retired
    Enable = 1'b0;
    tick(6'd0, 1'b1, 1'b0, 8'd16);
    tick(6'd0, 1'b1, 1'b0, 8'd16);
    Enable = 1'b1;
    tick(6'd4, 1'b1, 1'b0, 8'd17);
    tick(6'd8, 1'b1, 1'b0, 8'd18);

    // branch -8 from 8 -> 0
    Branch = 1'b1; Branch_off = 6'b111000;
    tick(6'd0, 1'b1, 1'b0, 8'd19);
    quiet();
    tick(6'd4, 1'b1, 1'b0, 8'd20);
    tick(6'd8, 1'b1, 1'b0, 8'd21);
    // branch +6 from 8 -> 14, low bits cleared -> 12
    Branch = 1'b1; Branch_off = 6'd6;
    tick(6'd12, 1'b1, 1'b0, 8'd22);
    quiet();
    tick(6'd16, 1'b1, 1'b0, 8'd23);
    tick(6'd20, 1'b1, 1'b0, 8'd24);

    // jump 33 with branch in the same cycle -> 32
    Jump = 1'b1; Jump_addr = 6'd33; Branch = 1'b1; Branch_off = 6'd8;
    tick(6'd32, 1'b1, 1'b0, 8'd25);
    quiet();

    // jump to 12, then stall three cycles, then leave with jump to 40
    Jump = 1'b1; Jump_addr = 6'd12;
    tick(6'd12, 1'b1, 1'b0, 8'd26);
    quiet();
    Stall = 1'b1; Jump = 1'b1; Jump_addr = 6'd52;
    for (int i = 0; i < 3; i++) tick(6'd12, 1'b1, 1'b0, 8'd26);
    quiet();
    Jump = 1'b1; Jump_addr = 6'd40;
    tick(6'd40, 1'b1, 1'b0, 8'd27);
    quiet();

    // Stall honoured while Enable=0
    Enable = 1'b0; Stall = 1'b1;
    tick(6'd40, 1'b1, 1'b0, 8'd27);
    Enable = 1'b1; Stall = 1'b0;
    tick(6'd44, 1'b1, 1'b0, 8'd28);

    // Halt beats Stall and Jump; HALT is sticky under toggling inputs
    Halt = 1'b1; Stall = 1'b1; Jump = 1'b1; Jump_addr = 6'd8;
    tick(6'd44, 1'b0, 1'b1, 8'd28);
    for (int i = 0; i < 10; i++) begin
      Halt       = 1'($urandom_range(0, 1));
      Stall      = 1'($urandom_range(0, 1));
      Jump       = 1'($urandom_range(0, 1));
      Branch     = 1'($urandom_range(0, 1));
      Enable     = 1'($urandom_range(0, 1));
      Jump_addr  = W'($urandom_range(0, 63));
      Branch_off = W'($urandom_range(0, 63));
      tick(6'd44, 1'b0, 1'b1, 8'd28);
    end
    quiet();
    Enable = 1'b1;
    RST_N = 1'b0; Jump = 1'b1; Jump_addr = 6'd24;
    tick(6'd0, 1'b0, 1'b0, 8'd0);
    quiet();
    RST_N = 1'b1;
    tick(6'd0, 1'b1, 1'b0, 8'd0);

    // Halt taken from STALL
    Stall = 1'b1;
    tick(6'd0, 1'b1, 1'b0, 8'd0);
    Halt = 1'b1;
    tick(6'd0, 1'b0, 1'b1, 8'd0);
    quiet();
    RST_N = 1'b0;
    tick(6'd0, 1'b0, 1'b0, 8'd0);
    RST_N = 1'b1;
    tick(6'd0, 1'b1, 1'b0, 8'd0);

    // 300 advances: Retired saturates at 255
    for (int i = 1; i <= 300; i++)
      tick(W'(4 * i), 1'b1, 1'b0, (i > 255) ? 8'd255 : 8'(i));

    // reset in RUN with a jump pending
    RST_N = 1'b0; Jump = 1'b1; Jump_addr = 6'd20;
    tick(6'd0, 1'b0, 1'b0, 8'd0);
    quiet();
    RST_N = 1'b1;
    tick(6'd0, 1'b1, 1'b0, 8'd0);
    tick(6'd4, 1'b1, 1'b0, 8'd1);

    // drain
    @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
